sum_serial_nb: RTL and testbench
================================

Name: sum_serial_nb

Overview:
Parametrised digit-serial adder/subtractor and the multi-cycle successor to the team's cascaded nibble adders. It adds two WIDTH-bit operands NIBBLE bits per clock, reusing one NIBBLE-bit slice adder and a registered carry. A start/busy/valid handshake lets a controller or ALU datapath trade latency for area at any width.

Parameters:
WIDTH, 16, operand and result width in bits; must be a positive multiple of NIBBLE (elaboration error otherwise).
NIBBLE, 4, bits processed per clock; 1 ≤ NIBBLE ≤ WIDTH.
STEPS (localparam), WIDTH/NIBBLE, slice cycles per operation.

Ports:
i_Clk  in  1  rising-edge clock
i_Reset  in  1  asynchronous, active-high reset
i_Start  in  1  request; sampled only in IDLE
i_Sub  in  1  0 = add, 1 = subtract; latched with i_Start
i_bit1  in  WIDTH  operand A; latched with i_Start
i_bit2  in  WIDTH  operand B; latched with i_Start
i_Carry  in  1  carry-in (not-borrow in subtract mode); latched with i_Start
o_Busy  out  1  high while in RUN
o_Valid  out  1  one-cycle pulse when a result completes
o_Suma  out  WIDTH  result; held until the next completion
o_Carry  out  1  carry out of the MSB
o_Overflow  out  1  two's-complement signed overflow
o_Zero  out  1  high when o_Suma == 0

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, slice counter = 0, carry register = 0, operand and result registers = 0. All outputs are 0 (o_Zero = 0 until the first completion).
- Arithmetic: add mode computes A + B + i_Carry. Subtract mode computes A + ~B + i_Carry, so i_Carry = 1 gives A − B. In both modes o_Carry = 1 means no borrow.
- IDLE: o_Busy = 0. If i_Start = 1 at a rising edge, latch A, B (inverted if i_Sub = 1) and i_Carry into the carry register, clear the counter and go to RUN. If i_Start = 0, stay in IDLE.
- RUN: o_Busy = 1. Each edge:
  - add slice [cnt*NIBBLE +: NIBBLE] of A and B' with the carry register;
  - write the NIBBLE-bit sum into the same slice of the result register;
  - update the carry register from the slice carry-out;
  - increment cnt.
  - Slices go LSB first.
- Completion: on the edge that processes slice STEPS−1:
  - state returns to IDLE;
  - o_Suma is updated from the result register;
  - o_Carry = final slice carry-out;
  - o_Overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]);
  - o_Zero = (sum == 0);
  - o_Valid = 1 for exactly one cycle.
- Latency and throughput:
  - i_Start sampled at edge t0; o_Busy high from t0 to t0+STEPS; o_Valid high during the cycle after edge t0+STEPS.
  - The next i_Start is accepted at edge t0+STEPS+1 at the earliest, which is the same cycle o_Valid is high. Back-to-back throughput is STEPS+1 cycles.
- i_Start while Busy is ignored, with no queueing. Input changes during RUN have no effect.
- o_Suma and the flags hold their values between completions. They change only at completion or reset.
- Reset asserted mid-RUN aborts the operation immediately. No o_Valid is produced and all outputs clear.
- STEPS = 1 (NIBBLE = WIDTH) is legal: the operation completes at edge t0+1.
- The counter width is $clog2(STEPS), minimum 1 bit. There is no wrap beyond STEPS−1.

Test Plan:
1. WIDTH=16, NIBBLE=4, add 0x00FF + 0x0001, i_Carry=0 -> o_Suma=0x0100, C=0, V=0, Z=0. o_Busy is high for exactly 4 cycles and o_Valid pulses once, 4 edges after start.
2. Add 0xFFFF + 0x0001, i_Carry=0 -> 0x0000, C=1, V=0, Z=1. Then add 0x7FFF + 0x0001 -> 0x8000, C=0, V=1, Z=0.
3. Subtract 0x8000 − 0x0001, i_Carry=1 -> 0x7FFF, C=1, V=1. Then subtract 0x0003 − 0x0005, i_Carry=1 -> 0xFFFE, C=0, V=0.
4. Pulse i_Start with operands 0x1234/0x1111, then pulse i_Start with 0xAAAA/0x5555 while Busy -> the second start is ignored and the result is 0x2345. A start at the first legal edge (o_Valid cycle) is accepted with no lost cycle.
5. Assert i_Reset for 1 cycle after 2 RUN edges -> all outputs 0 asynchronously and no o_Valid. A following 0x0001 + 0x0001 yields 0x0002.
6. Re-run the random add/sub regression at NIBBLE=1, 8 and 16 (WIDTH=16) and at WIDTH=32, NIBBLE=4 -> results and flags match the reference model, and latency equals STEPS each time.

Source files
------------

// File: rtl/sum_serial_nb.sv
// Digit-serial adder/subtractor: one NIBBLE-bit slice adder reused
// STEPS times with a registered carry, behind a start/busy/valid handshake.
module sum_serial_nb #(
    parameter int WIDTH  = 16,
    parameter int NIBBLE = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic             i_Sub,
    input  logic [WIDTH-1:0] i_bit1,
    input  logic [WIDTH-1:0] i_bit2,
    input  logic             i_Carry,
    output logic             o_Busy,
    output logic             o_Valid,
    output logic [WIDTH-1:0] o_Suma,
    output logic             o_Carry,
    output logic             o_Overflow,
    output logic             o_Zero
);

    localparam int STEPS = WIDTH / NIBBLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam logic [WIDTH-1:0] SL_MASK = WIDTH'({NIBBLE{1'b1}});

    generate
        if (NIBBLE < 1 || NIBBLE > WIDTH || (WIDTH % NIBBLE) != 0) begin : g_bad_cfg
            $error("sum_serial_nb: WIDTH must be a positive multiple of NIBBLE");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  res_q;

    logic [WIDTH-1:0]  suma_q;
    logic              carry_o_q;
    logic              ovf_q;
    logic              zero_q;
    logic              valid_q;

    logic [31:0]       shamt;
    logic [NIBBLE-1:0] a_sl;
    logic [NIBBLE-1:0] b_sl;
    logic [NIBBLE:0]   sl_sum;
    logic [WIDTH-1:0]  res_nxt;

    // State register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and busy: leave RUN on the edge that handles the last slice.
    always_comb begin
        state_nxt = state;
        o_Busy    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_Start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                o_Busy = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Slice adder: pick slice cnt by shifting, merge its sum back in place.
    always_comb begin
        shamt   = 32'(cnt) * 32'(NIBBLE);
        a_sl    = NIBBLE'(a_q >> shamt);
        b_sl    = NIBBLE'(b_q >> shamt);
        sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{NIBBLE{1'b0}}, carry_q};
        res_nxt = (res_q & ~(SL_MASK << shamt))
                | (WIDTH'(sl_sum[NIBBLE-1:0]) << shamt);
    end

    // Operand capture, per-slice accumulation and result/flag update.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            res_q     <= '0;
            suma_q    <= '0;
            carry_o_q <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state == IDLE) begin
                if (i_Start) begin
                    a_q     <= i_bit1;
                    b_q     <= i_Sub ? ~i_bit2 : i_bit2;
                    carry_q <= i_Carry;
                    cnt     <= '0;
                end
            end else begin
                res_q   <= res_nxt;
                carry_q <= sl_sum[NIBBLE];
                cnt     <= cnt + 1'b1;
                if (last) begin
                    cnt       <= '0;
                    suma_q    <= res_nxt;
                    carry_o_q <= sl_sum[NIBBLE];
                    ovf_q     <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                              && (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
                    zero_q    <= (res_nxt == '0);
                    valid_q   <= 1'b1;
                end
            end
        end
    end

    assign o_Valid    = valid_q;
    assign o_Suma     = suma_q;
    assign o_Carry    = carry_o_q;
    assign o_Overflow = ovf_q;
    assign o_Zero     = zero_q;

endmodule

// File: tb/tb_sum_serial_nb.sv
// Directed bench for sum_serial_nb: handshake timing, flags, reset abort,
// and a multi-configuration regression against a behavioural model.
module tb_sum_serial_nb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        busy, valid, c_o, v_o, z_o;
    logic [15:0] suma;

    logic        r_start, r_sub, r_cin;
    logic [31:0] r_a, r_b;

    logic        bs1, vl1, c1, v1, z1;
    logic [15:0] s1;
    logic        bs8, vl8, c8, v8, z8;
    logic [15:0] s8;
    logic        bs16, vl16, c16, v16, z16;
    logic [15:0] s16;
    logic        bs32, vl32, c32, v32, z32;
    logic [31:0] s32;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sum_serial_nb #(.WIDTH(16), .NIBBLE(4)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Sub(sub),
        .i_bit1(a), .i_bit2(b), .i_Carry(cin),
        .o_Busy(busy), .o_Valid(valid), .o_Suma(suma),
        .o_Carry(c_o), .o_Overflow(v_o), .o_Zero(z_o)
    );

    sum_serial_nb #(.WIDTH(16), .NIBBLE(1)) u_n1 (
        .i_Clk(clk), .i_Reset(rst), .i_Start(r_start), .i_Sub(r_sub),
        .i_bit1(r_a[15:0]), .i_bit2(r_b[15:0]), .i_Carry(r_cin),
        .o_Busy(bs1), .o_Valid(vl1), .o_Suma(s1),
        .o_Carry(c1), .o_Overflow(v1), .o_Zero(z1)
    );

    sum_serial_nb #(.WIDTH(16), .NIBBLE(8)) u_n8 (
        .i_Clk(clk), .i_Reset(rst), .i_Start(r_start), .i_Sub(r_sub),
        .i_bit1(r_a[15:0]), .i_bit2(r_b[15:0]), .i_Carry(r_cin),
        .o_Busy(bs8), .o_Valid(vl8), .o_Suma(s8),
        .o_Carry(c8), .o_Overflow(v8), .o_Zero(z8)
    );

    sum_serial_nb #(.WIDTH(16), .NIBBLE(16)) u_n16 (
        .i_Clk(clk), .i_Reset(rst), .i_Start(r_start), .i_Sub(r_sub),
        .i_bit1(r_a[15:0]), .i_bit2(r_b[15:0]), .i_Carry(r_cin),
        .o_Busy(bs16), .o_Valid(vl16), .o_Suma(s16),
        .o_Carry(c16), .o_Overflow(v16), .o_Zero(z16)
    );

    sum_serial_nb #(.WIDTH(32), .NIBBLE(4)) u_w32 (
        .i_Clk(clk), .i_Reset(rst), .i_Start(r_start), .i_Sub(r_sub),
        .i_bit1(r_a), .i_bit2(r_b), .i_Carry(r_cin),
        .o_Busy(bs32), .o_Valid(vl32), .o_Suma(s32),
        .o_Carry(c32), .o_Overflow(v32), .o_Zero(z32)
    );

    task automatic chk(input string tag, input logic [35:0] obs,
                       input logic [35:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: {sum[31:0], carry, overflow, zero} for a w-bit operation.
    function automatic logic [34:0] ref_op(input int w, input logic [31:0] ai,
                                           input logic [31:0] bi,
                                           input logic s, input logic ci);
        logic [31:0] msk, aa, bb, ss;
        logic [32:0] full;
        logic        cc, vv, zz;
        msk  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa   = ai & msk;
        bb   = (s ? ~bi : bi) & msk;
        full = {1'b0, aa} + {1'b0, bb} + {32'd0, ci};
        ss   = full[31:0] & msk;
        cc   = full[w];
        vv   = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
        zz   = (ss == 32'd0);
        return {ss, cc, vv, zz};
    endfunction

    // Starts an op in the current (post-negedge) cycle; returns at the
    // negedge where o_Valid is seen, or after the bound expires.
    task automatic do_op(input logic [15:0] ai, input logic [15:0] bi,
                         input logic s, input logic ci,
                         output int nb, output bit seen);
        a = ai; b = bi; sub = s; cin = ci; start = 1'b1;
        nb = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) seen = 1'b1;
            else if (busy) nb++;
        end
    endtask

    initial begin
        int  nb;
        bit  seen;
        int  vcnt;
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic        vc [8];

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0;
        a = '0; b = '0;
        r_start = 1'b0; r_sub = 1'b0; r_cin = 1'b0; r_a = '0; r_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_out", {busy, valid, suma, c_o, v_o, z_o}, '0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 0x00FF + 0x0001
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, nb, seen);
        chk("t1_valid", seen, 1'b1);
        chk("t1_busy_cycles", nb, 4);
        chk("t1_res", {suma, c_o, v_o, z_o}, {16'h0100, 3'b000});
        @(negedge clk);
        chk("t1_valid_once", valid, 1'b0);
        chk("t1_hold", suma, 16'h0100);

        // 2: carry-out/zero, then signed overflow
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, nb, seen);
        chk("t2a_res", {seen, suma, c_o, v_o, z_o}, {1'b1, 16'h0000, 3'b101});
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, nb, seen);
        chk("t2b_res", {seen, suma, c_o, v_o, z_o}, {1'b1, 16'h8000, 3'b010});
        chk("t2b_back2back", nb, 4);

        // 3: subtract
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, nb, seen);
        chk("t3a_res", {seen, suma, c_o, v_o, z_o}, {1'b1, 16'h7FFF, 3'b110});
        do_op(16'h0003, 16'h0005, 1'b1, 1'b1, nb, seen);
        chk("t3b_res", {seen, suma, c_o, v_o, z_o}, {1'b1, 16'hFFFE, 3'b000});

        // 4: start while busy is ignored, then start in the valid cycle
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t4_res", {seen, suma, c_o, v_o, z_o}, {1'b1, 16'h2345, 3'b000});
        do_op(16'h0010, 16'h0020, 1'b0, 1'b0, nb, seen);
        chk("t4_legal_start", {seen, suma}, {1'b1, 16'h0030});
        chk("t4_no_lost_cycle", nb, 4);

        // 5: reset mid-run
        a = 16'h4000; b = 16'h4000; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_async_clr", {busy, valid, suma, c_o, v_o, z_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        chk("t5_no_valid", vcnt, 0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, nb, seen);
        chk("t5_after", {seen, suma, c_o, v_o, z_o}, {1'b1, 16'h0002, 3'b000});

        // 6: regression across configurations
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vs[0] = 1'b0; vc[0] = 1'b0;
        va[1] = 32'h8000_8000; vb[1] = 32'h0000_0001; vs[1] = 1'b1; vc[1] = 1'b1;
        va[2] = 32'h7FFF_7FFF; vb[2] = 32'h0000_0001; vs[2] = 1'b0; vc[2] = 1'b1;
        for (int i = 3; i < 8; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            vs[i] = 1'($urandom_range(1));
            vc[i] = 1'($urandom_range(1));
        end
        for (int i = 0; i < 8; i++) begin
            int          l1, l8, l16, l32;
            logic [34:0] o1, o8, o16, o32;
            l1 = 0; l8 = 0; l16 = 0; l32 = 0;
            o1 = '0; o8 = '0; o16 = '0; o32 = '0;
            r_a = va[i]; r_b = vb[i]; r_sub = vs[i]; r_cin = vc[i];
            r_start = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                r_start = 1'b0;
                if (vl1 && l1 == 0) begin
                    l1 = k; o1 = {16'd0, s1, c1, v1, z1};
                end
                if (vl8 && l8 == 0) begin
                    l8 = k; o8 = {16'd0, s8, c8, v8, z8};
                end
                if (vl16 && l16 == 0) begin
                    l16 = k; o16 = {16'd0, s16, c16, v16, z16};
                end
                if (vl32 && l32 == 0) begin
                    l32 = k; o32 = {s32, c32, v32, z32};
                end
            end
            chk($sformatf("r%0d_n1_lat", i), l1, 17);
            chk($sformatf("r%0d_n8_lat", i), l8, 3);
            chk($sformatf("r%0d_n16_lat", i), l16, 2);
            chk($sformatf("r%0d_w32_lat", i), l32, 9);
            chk($sformatf("r%0d_n1_res", i), o1, ref_op(16, r_a, r_b, r_sub, r_cin));
            chk($sformatf("r%0d_n8_res", i), o8, ref_op(16, r_a, r_b, r_sub, r_cin));
            chk($sformatf("r%0d_n16_res", i), o16, ref_op(16, r_a, r_b, r_sub, r_cin));
            chk($sformatf("r%0d_w32_res", i), o32, ref_op(32, r_a, r_b, r_sub, r_cin));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
